// File: rtl/pipe_shifter_pkg.sv
// Shared definitions for pipe_shifter: opcode encoding, shift-amount width and
// helpers that spread the barrel levels over the register stages.
package pipe_shifter_pkg;

    localparam int SH_AMT_W = 32;

    typedef enum logic [1:0] {
        SH_OP_SRL = 2'b00,
        SH_OP_SLL = 2'b01,
        SH_OP_SRA = 2'b10,
        SH_OP_ROL = 2'b11
    } shOpT;

    // Earlier stages absorb the remainder when levels do not divide evenly.
    function automatic int grpStart(input int g, input int levels, input int stages);
        int base;
        int extra;
        base  = levels / stages;
        extra = levels % stages;
        return g * base + ((g < extra) ? g : extra);
    endfunction

    function automatic int grpCount(input int g, input int levels, input int stages);
        return levels / stages + ((g < levels % stages) ? 1 : 0);
    endfunction

endpackage

// File: rtl/pipe_shifter_shift_level.sv
// One barrel-shifter level: shifts by the fixed distance DIST when enabled.
// With SHIFT_CARRY_OUT_EN it also offers the last bit this level would push out.
module pipe_shifter_shift_level
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    input  logic             en_i,
`ifdef SHIFT_CARRY_OUT_EN
    output logic             carry_o,
`endif
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                SH_OP_SRL: data_o = data_i >> DIST;
                SH_OP_SLL: data_o = data_i << DIST;
                SH_OP_SRA: data_o = WIDTH'($signed(data_i) >>> DIST);
                default:   data_o = (data_i << DIST) | (data_i >> (WIDTH - DIST));
            endcase
        end
    end

`ifdef SHIFT_CARRY_OUT_EN
    // Rotates never lose a bit, so they offer no candidate.
    always_comb begin
        case (op_i)
            SH_OP_SLL: carry_o = data_i[WIDTH-DIST];
            SH_OP_ROL: carry_o = 1'b0;
            default:   carry_o = data_i[DIST-1];
        endcase
    end
`endif

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SRL/SLL/SRA/ROL) with valid/ready on both sides.
// Define SHIFT_CARRY_OUT_EN to add the out_cout_o carry-out port.
module pipe_shifter
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [WIDTH-1:0]    in_d_i,
    input  logic [SH_AMT_W-1:0] in_s_i,
    input  logic [1:0]          in_op_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
`ifdef SHIFT_CARRY_OUT_EN
    output logic                out_cout_o,
`endif
    output logic [WIDTH-1:0]    out_y_o
);

    localparam int LG = $clog2(WIDTH);

    logic adv;

    assign adv        = ~out_valid_o | out_ready_i;
    assign in_ready_o = adv;

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : stg
        localparam int FIRST = grpStart(g, LG, PIPE_STAGES);
        localparam int CNT   = grpCount(g, LG, PIPE_STAGES);

        logic              srcValid;
        logic [WIDTH-1:0]  srcData;
        logic [1:0]        srcOp;
        logic [LG-1:FIRST] srcAmt;
        logic              srcSat;
        logic              srcFill;
        logic [WIDTH-1:0]  lvlData [CNT+1];
`ifdef SHIFT_CARRY_OUT_EN
        logic              srcCarry;
        logic              srcSatC;
        logic              srcZero;
        logic              lvlCarry [CNT+1];
`endif

        if (g == 0) begin : head
            // Saturation is judged on the full amount; the levels only see the low bits.
            assign srcValid = in_valid_i;
            assign srcData  = in_d_i;
            assign srcOp    = in_op_i;
            assign srcAmt   = in_s_i[LG-1:0];
            assign srcSat   = (|in_s_i[SH_AMT_W-1:LG]) && (in_op_i != SH_OP_ROL);
            assign srcFill  = (in_op_i == SH_OP_SRA) && in_d_i[WIDTH-1];
`ifdef SHIFT_CARRY_OUT_EN
            logic exact;
            assign exact    = (in_s_i == SH_AMT_W'(WIDTH));
            assign srcCarry = 1'b0;
            assign srcZero  = (in_s_i == '0);
            always_comb begin
                case (in_op_i)
                    SH_OP_SRA: srcSatC = in_d_i[WIDTH-1];
                    SH_OP_SRL: srcSatC = exact & in_d_i[WIDTH-1];
                    SH_OP_SLL: srcSatC = exact & in_d_i[0];
                    default:   srcSatC = 1'b0;
                endcase
            end
`endif
        end else begin : body
            assign srcValid = stg[g-1].mid.valid_q;
            assign srcData  = stg[g-1].mid.data_q;
            assign srcOp    = stg[g-1].mid.op_q;
            assign srcAmt   = stg[g-1].mid.amt_q;
            assign srcSat   = stg[g-1].mid.sat_q;
            assign srcFill  = stg[g-1].mid.fill_q;
`ifdef SHIFT_CARRY_OUT_EN
            assign srcCarry = stg[g-1].mid.carry_q;
            assign srcSatC  = stg[g-1].mid.satc_q;
            assign srcZero  = stg[g-1].mid.zero_q;
`endif
        end

        assign lvlData[0] = srcData;
`ifdef SHIFT_CARRY_OUT_EN
        assign lvlCarry[0] = srcCarry;
`endif

        for (genvar j = 0; j < CNT; j++) begin : lvl
`ifdef SHIFT_CARRY_OUT_EN
            logic cand;
`endif
            pipe_shifter_shift_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << (FIRST + j))
            ) u_level (
                .data_i  (lvlData[j]),
                .op_i    (srcOp),
                .en_i    (srcAmt[FIRST+j]),
`ifdef SHIFT_CARRY_OUT_EN
                .carry_o (cand),
`endif
                .data_o  (lvlData[j+1])
            );
`ifdef SHIFT_CARRY_OUT_EN
            // The last enabled level is the one that pushed out the final bit.
            assign lvlCarry[j+1] = srcAmt[FIRST+j] ? cand : lvlCarry[j];
`endif
        end

        if (g < PIPE_STAGES - 1) begin : mid
            localparam int NEXT = FIRST + CNT;
            logic             valid_q;
            logic [WIDTH-1:0] data_q;
            logic [1:0]       op_q;
            logic [LG-1:NEXT] amt_q;
            logic             sat_q;
            logic             fill_q;
`ifdef SHIFT_CARRY_OUT_EN
            logic             carry_q;
            logic             satc_q;
            logic             zero_q;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    op_q    <= '0;
                    amt_q   <= '0;
                    sat_q   <= 1'b0;
                    fill_q  <= 1'b0;
`ifdef SHIFT_CARRY_OUT_EN
                    carry_q <= 1'b0;
                    satc_q  <= 1'b0;
                    zero_q  <= 1'b0;
`endif
                end else if (adv) begin
                    valid_q <= srcValid;
                    data_q  <= lvlData[CNT];
                    op_q    <= srcOp;
                    amt_q   <= srcAmt[LG-1:NEXT];
                    sat_q   <= srcSat;
                    fill_q  <= srcFill;
`ifdef SHIFT_CARRY_OUT_EN
                    carry_q <= lvlCarry[CNT];
                    satc_q  <= srcSatC;
                    zero_q  <= srcZero;
`endif
                end
            end
        end else begin : fin
            logic             valid_q;
            logic [WIDTH-1:0] y_d;
            logic [WIDTH-1:0] y_q;
`ifdef SHIFT_CARRY_OUT_EN
            logic             cout_d;
            logic             cout_q;
`endif

            always_comb begin
                y_d = srcSat ? {WIDTH{srcFill}} : lvlData[CNT];
            end

`ifdef SHIFT_CARRY_OUT_EN
            always_comb begin
                cout_d = lvlCarry[CNT];
                if (srcZero) begin
                    cout_d = 1'b0;
                end else if (srcOp == SH_OP_ROL) begin
                    cout_d = y_d[0];
                end else if (srcSat) begin
                    cout_d = srcSatC;
                end
            end
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    y_q     <= '0;
`ifdef SHIFT_CARRY_OUT_EN
                    cout_q  <= 1'b0;
`endif
                end else if (adv) begin
                    valid_q <= srcValid;
                    y_q     <= y_d;
`ifdef SHIFT_CARRY_OUT_EN
                    cout_q  <= cout_d;
`endif
                end
            end
        end
    end

    assign out_valid_o = stg[PIPE_STAGES-1].fin.valid_q;
    assign out_y_o     = stg[PIPE_STAGES-1].fin.y_q;
`ifdef SHIFT_CARRY_OUT_EN
    assign out_cout_o  = stg[PIPE_STAGES-1].fin.cout_q;
`endif

endmodule

// File: tb/tb_pipe_shifter.sv
// Randomised scoreboard bench for pipe_shifter against a plain-arithmetic shift model.
// Carry-out is compared only when SHIFT_CARRY_OUT_EN is defined.
module tb_pipe_shifter;

    localparam int W = 32;
    localparam int P = 2;

    typedef struct {
        logic [W-1:0] y;
        logic         c;
        int           acc;
        bit           lat;
    } expT;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] inD;
    logic [31:0]  inS;
    logic [1:0]   inOp;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] outY;
`ifdef SHIFT_CARRY_OUT_EN
    logic         outCout;
`endif

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  stimDone;

    logic [31:0] dirD [14] = '{32'h2, 32'd123, 32'h80000000, 32'h1, 32'h80000000, 32'h80000000,
                               32'h80000001, 32'h80000000, 32'd13, 32'h12345678, 32'h0000F0F0,
                               32'h000000A5, 32'hFFFFFFFF, 32'hC0000003};
    logic [31:0] dirS [14] = '{32'd4, 32'd3, 32'd32, 32'd35, 32'd3, 32'd40, 32'd33, 32'd1, 32'd3,
                               32'd0, 32'd0, 32'd31, 32'd32, 32'd32};
    logic [1:0]  dirOp [14] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00,
                                2'b11, 2'b10, 2'b00, 2'b01, 2'b11};

    pipe_shifter #(.WIDTH(W), .PIPE_STAGES(P)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .in_d_i      (inD),
        .in_s_i      (inS),
        .in_op_i     (inOp),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
`ifdef SHIFT_CARRY_OUT_EN
        .out_cout_o  (outCout),
`endif
        .out_y_o     (outY)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: shift rules stated directly in terms of the full amount s.
    function automatic void refModel(input logic [W-1:0] d, input logic [31:0] s,
                                     input logic [1:0] op, output logic [W-1:0] y, output logic c);
        int unsigned r;
        case (op)
            2'b00:   y = (s >= W) ? '0 : d >> s;
            2'b01:   y = (s >= W) ? '0 : d << s;
            2'b10:   y = (s >= W) ? {W{d[W-1]}} : W'($signed(d) >>> s);
            default: begin
                r = s % W;
                y = (r == 0) ? d : ((d << r) | (d >> (W - r)));
            end
        endcase
        if (s == 0) c = 1'b0;
        else begin
            case (op)
                2'b00:   c = (s <= W) ? d[s-1] : 1'b0;
                2'b01:   c = (s <= W) ? d[W-s] : 1'b0;
                2'b10:   c = (s <= W) ? d[s-1] : d[W-1];
                default: c = y[0];
            endcase
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Presents one op and holds it until accepted; the expectation is queued at acceptance.
    task automatic applyStimulus(input logic [W-1:0] d, input logic [31:0] s, input logic [1:0] op,
                                 input bit lat);
        expT e;
        bit  done = 0;
        int  tries = 0;
        inValid = 1'b1;
        inD     = d;
        inS     = s;
        inOp    = op;
        while (!done) begin
            @(negedge clk);
            if (inReady) begin
                refModel(d, s, op, e.y, e.c);
                e.acc = cyc + 1;
                e.lat = lat;
                expQ.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            tries++;
            if (!done && tries >= 50) begin
                checkOutput("acceptTimeout", 64'(inReady), 64'd1);
                done = 1;
            end
        end
        inValid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && expQ.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput(name, 64'(expQ.size()), 64'd0);
    endtask

    function automatic logic [31:0] randAmt();
        case ($urandom_range(7))
            0:       return 32'd0;
            1:       return 32'(W);
            2:       return 32'(W - 1);
            3:       return 32'(W + 1);
            4:       return 32'($urandom_range(W - 1));
            5:       return $urandom;
            6:       return 32'($urandom_range(2 * W));
            default: return 32'($urandom_range(W - 1) + W * $urandom_range(4));
        endcase
    endfunction

    // Monitor: pops on every output transfer and watches stall behaviour.
    initial begin : monitor
        expT          e;
        logic [W-1:0] heldY;
        bit           held;
        held = 0;
        heldY = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 0;
                continue;
            end
            if (held) begin
                checkOutput("stallValid", 64'(outValid), 64'd1);
                checkOutput("stallHoldY", 64'(outY), 64'(heldY));
            end
            if (outValid && !outReady) begin
                checkOutput("inReadyStall", 64'(inReady), 64'd0);
                held  = 1;
                heldY = outY;
            end else begin
                held = 0;
            end
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedOutput actual=%h required=none (t=%0t)", outY, $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("resultY", 64'(outY), 64'(e.y));
`ifdef SHIFT_CARRY_OUT_EN
                    checkOutput("resultCout", 64'(outCout), 64'(e.c));
`endif
                    if (e.lat) checkOutput("latency", 64'(cyc - e.acc), 64'(P - 1));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : driver
        rst_n    = 1'b0;
        inValid  = 1'b0;
        inD      = '0;
        inS      = '0;
        inOp     = '0;
        outReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValid", 64'(outValid), 64'd0);
        checkOutput("rstY", 64'(outY), 64'd0);
        checkOutput("rstInReady", 64'(inReady), 64'd1);
`ifdef SHIFT_CARRY_OUT_EN
        checkOutput("rstCout", 64'(outCout), 64'd0);
`endif
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idleNoOutput", 64'(outValid), 64'd0);
        end
        @(posedge clk);
        #1;

        $display("[TB] directed ops, full rate");
        outReady = 1'b1;
        for (int i = 0; i < 14; i++) applyStimulus(W'(dirD[i]), dirS[i], dirOp[i], 1'b1);
        drain("drainDirected");

        $display("[TB] six back-to-back ops with a 3-cycle output stall");
        fork
            for (int i = 0; i < 6; i++)
                applyStimulus(W'({$urandom, $urandom}), randAmt(), 2'($urandom_range(3)), 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1;
                outReady = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                outReady = 1'b1;
            end
        join
        drain("drainBackpressure");

        $display("[TB] random ops with random backpressure");
        stimDone = 0;
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus(W'({$urandom, $urandom}), randAmt(), 2'($urandom_range(3)), 1'b0);
                end
                stimDone = 1;
            end
            while (!stimDone) begin
                @(posedge clk);
                #1;
                outReady = ($urandom_range(9) < 7);
            end
        join
        outReady = 1'b1;
        drain("drainRandom");

        $display("[TB] reset with two ops in flight");
        outReady = 1'b0;
        applyStimulus(32'h0000_00FF, 32'd4, 2'b01, 1'b0);
        applyStimulus(32'h1234_5678, 32'd8, 2'b11, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("flushValid", 64'(outValid), 64'd0);
        checkOutput("flushY", 64'(outY), 64'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        outReady = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("noGhostOutput", 64'(outValid), 64'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(32'h8000_0000, 32'd3, 2'b10, 1'b1);
        drain("drainAfterReset");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
